// File: rtl/scpad_unswizzle.sv
// rtl/scpad_unswizzle.sv - scratchpad read-return unswizzler with credit-gated response FIFO
module scpad_unswizzle #(
    parameter int NUM_COLS      = 32,
    parameter int ELEM_WIDTH    = 16,
    parameter int ROW_IDX_WIDTH = 10,
    parameter int COL_IDX_WIDTH = $clog2(NUM_COLS),
    parameter int BANK_LAT      = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_row_or_col,
    input  logic [ROW_IDX_WIDTH-1:0]       req_spad_addr,
    input  logic [ROW_IDX_WIDTH-1:0]       req_row_id,
    input  logic [COL_IDX_WIDTH-1:0]       req_col_id,
    input  logic [COL_IDX_WIDTH-1:0]       req_num,
    input  logic [TAG_WIDTH-1:0]           req_tag,
    input  logic [NUM_COLS*ELEM_WIDTH-1:0] bank_rdata,
    input  logic                           bank_rvalid,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [NUM_COLS*ELEM_WIDTH-1:0] rsp_data,
    output logic [NUM_COLS-1:0]            rsp_mask,
    output logic [TAG_WIDTH-1:0]           rsp_tag,
    output logic                           err
);

    localparam int DATA_W = NUM_COLS * ELEM_WIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + BANK_LAT + 1);

    // row holds the absolute row in row-major mode, the base row in column-major mode
    typedef struct packed {
        logic                     row_or_col;
        logic [ROW_IDX_WIDTH-1:0] row;
        logic [COL_IDX_WIDTH-1:0] col_id;
        logic [COL_IDX_WIDTH-1:0] num;
        logic [TAG_WIDTH-1:0]     tag;
    } desc_t;

    desc_t                pipe_desc [BANK_LAT];
    logic [BANK_LAT-1:0]  pipe_valid;
    desc_t                in_desc;
    desc_t                out_desc;
    logic                 out_valid;
    logic                 accept;
    logic                 ready_en;

    logic [DATA_W-1:0]    data_mem [FIFO_DEPTH];
    logic [NUM_COLS-1:0]  mask_mem [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     occ;
    logic                 fifo_push;
    logic                 fifo_pop;

    logic [DATA_W-1:0]        unswz_data;
    logic [NUM_COLS-1:0]      unswz_mask;
    logic [COL_IDX_WIDTH-1:0] lane_idx;
    logic [COL_IDX_WIDTH-1:0] phys;
    logic [ROW_IDX_WIDTH-1:0] a_j;
    logic [CNT_W-1:0]         inflight;
    logic [CNT_W-1:0]         credits_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign accept    = req_valid && req_ready;
    assign out_desc  = pipe_desc[BANK_LAT-1];
    assign out_valid = pipe_valid[BANK_LAT-1];
    assign fifo_push = out_valid && bank_rvalid;
    assign fifo_pop  = rsp_valid && rsp_ready;

    always_comb begin
        in_desc            = '0;
        in_desc.row_or_col = req_row_or_col;
        in_desc.row        = req_row_or_col ? (req_spad_addr + req_row_id) : req_spad_addr;
        in_desc.col_id     = req_col_id;
        in_desc.num        = req_num;
        in_desc.tag        = req_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < BANK_LAT; i++) begin
                pipe_desc[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_desc[0]  <= in_desc;
            for (int i = 1; i < BANK_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_desc[i]  <= pipe_desc[i-1];
            end
        end
    end

    // Undo the XOR bank swizzle: logical lane j lives in physical bank phys
    always_comb begin
        unswz_data = '0;
        unswz_mask = '0;
        lane_idx   = '0;
        phys       = '0;
        a_j        = '0;
        for (int j = 0; j < NUM_COLS; j++) begin
            lane_idx = COL_IDX_WIDTH'(j);
            a_j      = out_desc.row + ROW_IDX_WIDTH'(j);
            if (out_desc.row_or_col) begin
                phys = lane_idx ^ out_desc.row[COL_IDX_WIDTH-1:0];
            end else begin
                phys = out_desc.col_id ^ a_j[COL_IDX_WIDTH-1:0];
            end
            if (lane_idx <= out_desc.num) begin
                unswz_mask[j]                       = 1'b1;
                unswz_data[j*ELEM_WIDTH +: ELEM_WIDTH] = bank_rdata[phys*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                mask_mem[i] <= '0;
                tag_mem[i]  <= '0;
            end
        end else begin
            if (fifo_push) begin
                data_mem[wr_ptr] <= unswz_data;
                mask_mem[wr_ptr] <= unswz_mask;
                tag_mem[wr_ptr]  <= out_desc.tag;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (fifo_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // A descriptor leaving the pipe without bank data (or the reverse) is dropped;
    // its credit returns simply because it no longer counts as inflight.
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (out_valid ^ bank_rvalid) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < BANK_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_valid[i]);
        end
        credits_used = inflight + CNT_W'(occ);
    end

    assign req_ready = ready_en && (credits_used < CNT_W'(FIFO_DEPTH));
    assign rsp_valid = (occ != '0);
    assign rsp_data  = data_mem[rd_ptr];
    assign rsp_mask  = mask_mem[rd_ptr];
    assign rsp_tag   = tag_mem[rd_ptr];

endmodule

// File: tb/tb_scpad_unswizzle.sv
// tb/tb_scpad_unswizzle.sv - directed table-driven bench for scpad_unswizzle
module tb_scpad_unswizzle;

    localparam int NUM_COLS      = 32;
    localparam int ELEM_WIDTH    = 16;
    localparam int ROW_IDX_WIDTH = 10;
    localparam int COL_IDX_WIDTH = 5;
    localparam int BANK_LAT      = 2;
    localparam int FIFO_DEPTH    = 4;
    localparam int TAG_WIDTH     = 4;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_row_or_col;
    logic [ROW_IDX_WIDTH-1:0]       req_spad_addr;
    logic [ROW_IDX_WIDTH-1:0]       req_row_id;
    logic [COL_IDX_WIDTH-1:0]       req_col_id;
    logic [COL_IDX_WIDTH-1:0]       req_num;
    logic [TAG_WIDTH-1:0]           req_tag;
    logic [NUM_COLS*ELEM_WIDTH-1:0] bank_rdata;
    logic                           bank_rvalid;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [NUM_COLS*ELEM_WIDTH-1:0] rsp_data;
    logic [NUM_COLS-1:0]            rsp_mask;
    logic [TAG_WIDTH-1:0]           rsp_tag;
    logic                           err;

    always #5 clk = ~clk;

    scpad_unswizzle #(
        .NUM_COLS(NUM_COLS), .ELEM_WIDTH(ELEM_WIDTH), .ROW_IDX_WIDTH(ROW_IDX_WIDTH),
        .COL_IDX_WIDTH(COL_IDX_WIDTH), .BANK_LAT(BANK_LAT), .FIFO_DEPTH(FIFO_DEPTH),
        .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_row_or_col(req_row_or_col),
        .req_spad_addr(req_spad_addr), .req_row_id(req_row_id), .req_col_id(req_col_id),
        .req_num(req_num), .req_tag(req_tag),
        .bank_rdata(bank_rdata), .bank_rvalid(bank_rvalid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_mask(rsp_mask), .rsp_tag(rsp_tag), .err(err)
    );

    typedef struct {
        logic        mode;
        logic [9:0]  spad;
        logic [9:0]  row_id;
        logic [4:0]  col_id;
        logic [4:0]  num;
        logic [3:0]  tag;
        logic [15:0] e0, e1, e2, e3, e31;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs [7];

    int checks = 0;
    int errors = 0;
    logic                auto_bank;
    logic [BANK_LAT-1:0] hist;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; the bank model returns bank_rvalid BANK_LAT cycles after each accept
    task automatic tick();
        logic acc;
        acc = req_valid && req_ready;
        @(posedge clk);
        #1;
        if (rst) hist = '0;
        else     hist = {hist[BANK_LAT-2:0], acc};
        bank_rvalid = auto_bank ? hist[BANK_LAT-1] : 1'b0;
    endtask

    function automatic logic [15:0] lane(input int j);
        return rsp_data[j*ELEM_WIDTH +: ELEM_WIDTH];
    endfunction

    task automatic set_req(input logic mode, input logic [9:0] spad, input logic [9:0] row_id,
                           input logic [4:0] col_id, input logic [4:0] num, input logic [3:0] tag);
        req_row_or_col = mode;
        req_spad_addr  = spad;
        req_row_id     = row_id;
        req_col_id     = col_id;
        req_num        = num;
        req_tag        = tag;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int lat;
    int acc_cnt;
    int bad_lanes;

    initial begin
        vecs[0] = '{1'b1, 10'd5,    10'd2,  5'd0,  5'd3,  4'd1, 16'hA007, 16'hA006, 16'hA005, 16'hA004, 16'h0000, 32'h0000000F};
        vecs[1] = '{1'b0, 10'd30,   10'd0,  5'd4,  5'd31, 4'd2, 16'hA01A, 16'hA01B, 16'hA004, 16'hA005, 16'hA019, 32'hFFFFFFFF};
        vecs[2] = '{1'b1, 10'd1023, 10'd2,  5'd0,  5'd31, 4'd3, 16'hA001, 16'hA000, 16'hA003, 16'hA002, 16'hA01E, 32'hFFFFFFFF};
        vecs[3] = '{1'b1, 10'd0,    10'd0,  5'd0,  5'd0,  4'd4, 16'hA000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'h00000001};
        vecs[4] = '{1'b0, 10'd0,    10'd0,  5'd0,  5'd31, 4'd5, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA01F, 32'hFFFFFFFF};
        vecs[5] = '{1'b0, 10'd1020, 10'd0,  5'd31, 5'd15, 4'd6, 16'hA003, 16'hA002, 16'hA001, 16'hA000, 16'h0000, 32'h0000FFFF};
        vecs[6] = '{1'b1, 10'd100,  10'd50, 5'd0,  5'd7,  4'd7, 16'hA016, 16'hA017, 16'hA014, 16'hA015, 16'h0000, 32'h000000FF};

        for (int k = 0; k < NUM_COLS; k++) begin
            bank_rdata[k*ELEM_WIDTH +: ELEM_WIDTH] = 16'hA000 | 16'(k);
        end
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; bank_rvalid = 1'b0;
        auto_bank = 1'b1; hist = '0;
        set_req(1'b0, '0, '0, '0, '0, '0);

        tick();
        tick();
        check("ready_in_reset", req_ready, 1'b0);
        rst = 1'b0;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_tag", rsp_tag, '0);
        check("reset_mask", rsp_mask, '0);
        check("reset_data_zero", rsp_data == '0, 1'b1);
        tick();
        check("ready_after_reset", req_ready, 1'b1);

        for (int v = 0; v < 7; v++) begin
            set_req(vecs[v].mode, vecs[v].spad, vecs[v].row_id, vecs[v].col_id, vecs[v].num, vecs[v].tag);
            check($sformatf("v%0d_req_ready", v), req_ready, 1'b1);
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            wait_rsp(lat);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'(BANK_LAT));
            check($sformatf("v%0d_tag", v), rsp_tag, vecs[v].tag);
            check($sformatf("v%0d_mask", v), rsp_mask, vecs[v].mask);
            check($sformatf("v%0d_lane0", v), lane(0), vecs[v].e0);
            check($sformatf("v%0d_lane1", v), lane(1), vecs[v].e1);
            check($sformatf("v%0d_lane2", v), lane(2), vecs[v].e2);
            check($sformatf("v%0d_lane3", v), lane(3), vecs[v].e3);
            check($sformatf("v%0d_lane31", v), lane(31), vecs[v].e31);
            bad_lanes = 0;
            for (int j = 0; j < NUM_COLS; j++) begin
                if (j > int'(vecs[v].num) && lane(j) != 16'h0) bad_lanes++;
            end
            check($sformatf("v%0d_masked_lanes_zero", v), 64'(bad_lanes), 64'd0);
            pop();
            check($sformatf("v%0d_empty_after_pop", v), rsp_valid, 1'b0);
        end
        check("no_err_after_vectors", err, 1'b0);

        // Backpressure: only FIFO_DEPTH requests fit while the requester stalls
        set_req(1'b1, 10'd0, 10'd0, 5'd0, 5'd31, 4'd0);
        req_valid = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            req_tag = 4'(i);
            if (i == 4) check("bp_ready_low_cycle4", req_ready, 1'b0);
            if (req_ready) acc_cnt++;
            tick();
        end
        req_valid = 1'b0;
        check("bp_accepted", 64'(acc_cnt), 64'd4);
        tick();
        tick();
        check("bp_full_valid", rsp_valid, 1'b1);
        check("bp_full_ready_low", req_ready, 1'b0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_pop%0d_valid_tag", k), {rsp_valid, rsp_tag}, {1'b1, 4'(k)});
            tick();
            if (k == 0) check("bp_ready_after_first_pop", req_ready, 1'b1);
        end
        rsp_ready = 1'b0;
        check("bp_drained", rsp_valid, 1'b0);

        // Reset while three requests are in flight
        set_req(1'b1, 10'd5, 10'd2, 5'd0, 5'd3, 4'd8);
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_tag = 4'(8 + i);
            tick();
        end
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_err", err, 1'b0);
        tick();
        check("midrst_ready", req_ready, 1'b1);
        tick();
        tick();
        check("midrst_no_stale_rsp", rsp_valid, 1'b0);
        check("midrst_err_still_clear", err, 1'b0);
        set_req(1'b1, 10'd5, 10'd2, 5'd0, 5'd3, 4'hC);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_rsp(lat);
        check("midrst_latency", 64'(lat), 64'(BANK_LAT));
        check("midrst_tag", rsp_tag, 4'hC);
        check("midrst_lane0", lane(0), 16'hA007);
        check("midrst_lane3", lane(3), 16'hA004);
        pop();

        // Mismatch: stray bank_rvalid, then requests whose bank data never comes
        auto_bank = 1'b0;
        bank_rvalid = 1'b1;
        tick();
        check("stray_rvalid_err", err, 1'b1);
        tick();
        tick();
        check("stray_no_write", rsp_valid, 1'b0);
        check("stray_err_sticky", err, 1'b1);
        req_valid = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            req_tag = 4'(i);
            if (req_ready) acc_cnt++;
            tick();
        end
        req_valid = 1'b0;
        check("withheld_accepted", 64'(acc_cnt), 64'd4);
        for (int i = 0; i < 4; i++) tick();
        check("withheld_no_rsp", rsp_valid, 1'b0);
        check("withheld_ready", req_ready, 1'b1);
        check("withheld_err", err, 1'b1);

        // All credits must be back: exactly FIFO_DEPTH fit again
        auto_bank = 1'b1;
        req_valid = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            req_tag = 4'(i);
            if (req_ready) acc_cnt++;
            tick();
        end
        req_valid = 1'b0;
        check("credit_restored", 64'(acc_cnt), 64'd4);
        tick();
        tick();
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("refill_pop%0d_tag", k), {rsp_valid, rsp_tag}, {1'b1, 4'(k)});
            tick();
        end
        rsp_ready = 1'b0;
        check("refill_drained", rsp_valid, 1'b0);
        check("err_final", err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scpad_unswizzle.md
# scpad_unswizzle

Read-return unswizzler for the scratchpad. It accepts the same row/column read request the swizzle stage decodes and tracks it through the fixed bank-read latency. When the banks return data, it undoes the XOR bank swizzle so lanes come back in logical order. It sits between the scratchpad bank array's read-data outputs and the requester (vector unit / DMA). A credit-gated response FIFO absorbs requester backpressure, because the banks themselves cannot stall.

## Interface
- NUM_COLS, 32: banks per row = lanes per response; power of two.
- ELEM_WIDTH, 16: bits per bank element.
- ROW_IDX_WIDTH, 10: scratchpad row-address width.
- COL_IDX_WIDTH, $clog2(NUM_COLS): lane/bank index width.
- BANK_LAT, 2: cycles from request accept to bank_rvalid; ≥1.
- FIFO_DEPTH, 4: response FIFO entries; ≥2.
- TAG_WIDTH, 4: opaque request tag.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  read request offered.
- req_ready  out  1  request accepted when high with req_valid.
- req_row_or_col  in  1  1 = row-major, 0 = column-major.
- req_spad_addr  in  ROW_IDX_WIDTH  base row.
- req_row_id  in  ROW_IDX_WIDTH  row offset (row-major only).
- req_col_id  in  COL_IDX_WIDTH  logical column (column-major only).
- req_num  in  COL_IDX_WIDTH  last valid lane index, inclusive.
- req_tag  in  TAG_WIDTH  returned with response.
- bank_rdata  in  NUM_COLS×ELEM_WIDTH  physical bank outputs; bank k at bits [k*ELEM_WIDTH +: ELEM_WIDTH].
- bank_rvalid  in  1  bank data valid this cycle.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester takes response.
- rsp_data  out  NUM_COLS×ELEM_WIDTH  logical-order lanes.
- rsp_mask  out  NUM_COLS  lane j valid iff j ≤ req_num.
- rsp_tag  out  TAG_WIDTH  tag of the response.
- err  out  1  sticky protocol error.

## Operation
**Tracking pipeline.** On accept, the block pushes a descriptor into a BANK_LAT-deep shift pipeline. The descriptor holds mode, abs/base row, col_id, num and tag.
- Row-major: r = (spad_addr + row_id) mod 2^ROW_IDX_WIDTH.
- Column-major: store spad_addr and col_id.

**Unswizzle** (combinational on the pipeline output), for lane j:
- Row-major: phys = j ^ (r & (NUM_COLS-1)).
- Column-major: a_j = (spad_addr + j) mod 2^ROW_IDX_WIDTH, then phys = col_id ^ (a_j & (NUM_COLS-1)).
- Lane j = bank_rdata[phys] if j ≤ num, else 0.
- mask[j] = (j ≤ num).

**FIFO write and mismatch handling.**
- When the pipeline output valid and bank_rvalid are both high, the unswizzled data, mask and tag are written to the FIFO.
- Pipeline-valid without bank_rvalid, or bank_rvalid without pipeline-valid:
  - err is set (cleared only by rst);
  - the entry/data is dropped;
  - the credit is returned.

**Credits.**
- inflight = valid entries in the pipeline; occ = FIFO occupancy.
- req_ready = (inflight + occ) < FIFO_DEPTH.
- req_ready is computed combinationally from registered state only; it does not depend on req_valid or rsp_ready.
- Consequence: the FIFO can never overflow.

**FIFO.** Circular, in-order, pointer wrap at FIFO_DEPTH. A simultaneous push and pop on a full or empty FIFO is legal; occupancy is unchanged for push+pop.

**Reset.**
- Clears the pipeline, FIFO pointers, occupancy and err.
- All outputs reset to 0, except req_ready = 1 in the cycle after reset deasserts (0 while rst is high).
- Requests in flight are discarded. A bank_rvalid arriving after reset for a pre-reset request sets err.

## Timing
- Request accepted at cycle t → descriptor reaches the pipeline output at t+BANK_LAT. bank_rvalid is expected that same cycle.
- FIFO write at the edge ending t+BANK_LAT. rsp_valid is high at t+BANK_LAT+1 if the FIFO was empty. Latency = BANK_LAT+1.
- rsp_data, rsp_mask and rsp_tag come from registered FIFO storage. They are stable while rsp_valid && !rsp_ready.
- Pop on rsp_valid && rsp_ready. The next entry is presented the following cycle; there are no bubbles.
- Throughput: 1 request/cycle while credits remain.
- A pop frees a credit: req_ready rises the cycle after the pop.

## Test plan
- **Row-major.** NUM_COLS=32, bank_rdata[k]=k, spad_addr=5, row_id=2, num=3 → lanes 0..3 = 7, 6, 5, 4; lanes 4..31 = 0; rsp_mask=0x0000000F; rsp_valid at t+3.
- **Column-major with wrap.** col_id=4, spad_addr=30, num=31, bank_rdata[k]=k → lane0=26, lane1=27, lane2=4, lane3=5; mask=0xFFFFFFFF.
- **Row-address wrap.** spad_addr=1023, row_id=2 (ROW_IDX_WIDTH=10) → r=1, lane j = j^1.
- **Backpressure.** rsp_ready=0, issue 6 back-to-back requests, tags 0..5:
  - exactly 4 accepted; req_ready low from cycle 4;
  - release rsp_ready → tags 0, 1, 2, 3 on consecutive cycles;
  - req_ready returns the cycle after the first pop.
- **Mismatch.** bank_rvalid pulse with no outstanding request → err=1 and stays 1; no FIFO write. Request with bank_rvalid withheld → err=1; no response; credit restored.
- **Reset mid-operation.** 3 requests in flight, assert rst one cycle:
  - rsp_valid=0 and err=0;
  - req_ready=1 after rst falls;
  - a new request returns correct data at BANK_LAT+1.
